// File: rtl/mfp_gpio_debounce_pkg.sv
// Shared constants for the GPIO input conditioner (board channel counts, debounce depths).
package mfp_gpio_debounce_pkg;

    localparam int unsigned MFP_N_SW          = 16;
    localparam int unsigned MFP_N_PB          = 5;
    localparam int unsigned MFP_DB_CYCLES_HW  = 500000;
    localparam int unsigned MFP_DB_CYCLES_SIM = 4;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Synchroniser depth outside 2..4 is pulled to the nearest legal value.
    function automatic int unsigned legal_sync_depth(input int unsigned n);
        if (n < SYNC_STAGES_MIN)
            return SYNC_STAGES_MIN;
        else if (n > SYNC_STAGES_MAX)
            return SYNC_STAGES_MAX;
        else
            return n;
    endfunction

endpackage

// File: rtl/mfp_debounce_ch.sv
// One debounce channel: pin synchroniser, consecutive-sample counter, stable level and edge pulses.
module mfp_debounce_ch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 4,
    parameter int   CNT_W       = 3,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic in_raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   done;

    assign sync_q = sync_r[SYNC_STAGES-1];
    assign done   = (sync_q != stable) && (cnt == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_r <= {SYNC_STAGES{RESET_BIT}};
            stable <= RESET_BIT;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in_raw};
            rise   <= done & sync_q;
            fall   <= done & ~sync_q;
            // Any return to the stable level, or an accepted change, restarts the count.
            if ((sync_q == stable) || done)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (done)
                stable <= sync_q;
        end
    end

endmodule

// File: rtl/mfp_gpio_debounce.sv
// Multi-channel switch/button conditioner with sticky change flags; level irq when
// MFP_GPIO_DEBOUNCE_IRQ_EN is defined, otherwise irq is tied low.
module mfp_gpio_debounce
    import mfp_gpio_debounce_pkg::*;
#(
    parameter int              N_CH        = 16,
    parameter int              SYNC_STAGES = 2,
    parameter int              DB_CYCLES   = 4,
    parameter int              CNT_W       = $clog2(DB_CYCLES + 1),
    parameter logic [N_CH-1:0] RESET_VAL   = {N_CH{1'b0}}
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [N_CH-1:0] in_raw,
    input  logic            clr_en,
    input  logic [N_CH-1:0] clr_mask,
    input  logic [N_CH-1:0] irq_mask,
    output logic [N_CH-1:0] stable,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] changed,
    output logic            irq
);

    localparam int SYNC_N = int'(legal_sync_depth(SYNC_STAGES));

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mfp_debounce_ch #(
            .SYNC_STAGES (SYNC_N),
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W),
            .RESET_BIT   (RESET_VAL[i])
        ) u_ch (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .in_raw  (in_raw[i]),
            .stable  (stable[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // A new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            changed <= '0;
        else
            changed <= (changed & ~({N_CH{clr_en}} & clr_mask)) | rise | fall;
    end

`ifdef MFP_GPIO_DEBOUNCE_IRQ_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            irq <= 1'b0;
        else
            irq <= |(changed & irq_mask);
    end
`else
    logic irq_mask_unused;
    assign irq_mask_unused = ^irq_mask;
    assign irq             = 1'b0;
`endif

endmodule
